// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit. The Control decoder uses the
// same MDOp constants to generate start/MDOp.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO for the Execute stage.
// state   | meaning
// MD_IDLE | ready to accept; MTHI/MTLO write HI/LO directly
// MD_BUSY | counting down; pending {hi,lo} commits when count reaches 1
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [63:0]       pend_q, pend_d;
  logic              skip_q, skip_d;

  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] a_s, b_s, quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Dividing by 1 in the zero and overflow cases keeps the divider defined;
  // for 0x80000000 / -1 it also yields exactly the required LO=A, HI=0.
  assign div_zero = (B == 32'd0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign b_safe   = (div_zero || div_ovf) ? 32'd1 : B;
  assign a_s      = $signed(A);
  assign b_s      = $signed(b_safe);
  assign quo_s    = a_s / b_s;
  assign rem_s    = a_s % b_s;
  assign quo_u    = A / b_safe;
  assign rem_u    = A % b_safe;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    skip_d  = skip_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (MDOp)
            MD_MULT: begin
              pend_d  = prod_s;
              skip_d  = 1'b0;
              count_d = MULT_LOAD;
              state_d = MD_BUSY;
            end
            MD_MULTU: begin
              pend_d  = prod_u;
              skip_d  = 1'b0;
              count_d = MULT_LOAD;
              state_d = MD_BUSY;
            end
            MD_DIV: begin
              pend_d  = {rem_s, quo_s};
              skip_d  = div_zero;
              count_d = DIV_LOAD;
              state_d = MD_BUSY;
            end
            MD_DIVU: begin
              pend_d  = {rem_u, quo_u};
              skip_d  = div_zero;
              count_d = DIV_LOAD;
              state_d = MD_BUSY;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = MD_IDLE;
          if (!skip_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
